// File: rtl/wb_bram_pkg.sv
// Shared types and defaults for the Wishbone-to-BRAM bridge.
// Both the controller and its wait-state counter import this package.
package wb_bram_pkg;

  localparam int          DATA_W        = 32;
  localparam int          CNT_W         = 8;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h3800_0000;
  localparam logic [31:0] DEF_ADDR_MASK = 32'hFFC0_0000;
  localparam int          DEF_DELAYS    = 10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    ACCESS  = 3'd2,
    CAPTURE = 3'd3,
    ACK     = 3'd4
  } state_t;

endpackage

// File: rtl/wb_bram_delay_cnt.sv
// Loadable 8-bit down-counter that times the wait states before a BRAM access.
// It saturates at zero, so the count can never wrap around.
module wb_bram_delay_cnt
  import wb_bram_pkg::*;
(
  input  logic             clk,
  input  logic             srst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/wb_bram_ctrl.sv
// Wishbone classic slave in front of a byte-writable single-port BRAM.
// Flow: decode the window, wait DELAYS cycles, make one BRAM access, then send one ack.
module wb_bram_ctrl
  import wb_bram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [31:0] ADDR_MASK = DEF_ADDR_MASK,
  parameter int          DELAYS    = DEF_DELAYS,
  parameter int          N         = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [DATA_W-1:0] wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [DATA_W-1:0] wbs_dat_o,
  output logic [3:0]        bram_we,
  output logic              bram_en,
  output logic [DATA_W-1:0] bram_di,
  output logic [31:0]       bram_a,
  input  logic [DATA_W-1:0] bram_do
);

  // With DELAYS == 0 the counter is never consulted, so any load value is harmless.
  localparam logic [CNT_W-1:0] LOAD_VAL = (DELAYS == 0) ? '0 : CNT_W'(DELAYS - 1);

  state_t            state_reg, state_next;
  logic [N-1:0]      word_reg;
  logic [DATA_W-1:0] dat_reg;
  logic [3:0]        sel_reg;
  logic              we_reg;
  logic              ack_reg;
  logic [DATA_W-1:0] rdata_reg;

  logic hit, req, cnt_load, cnt_dec, cnt_zero;

  assign hit = ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
  assign req = wbs_cyc_i && wbs_stb_i && hit;

  wb_bram_delay_cnt u_delay_cnt (
    .clk      (wb_clk_i),
    .srst     (wb_rst_i),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (LOAD_VAL),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_next = state_reg;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          cnt_load   = 1'b1;
          state_next = (DELAYS == 0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        // A master that drops cyc gives up the transfer before the BRAM sees it.
        if (!wbs_cyc_i) begin
          state_next = IDLE;
        end else if (cnt_zero) begin
          state_next = ACCESS;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ACCESS:  state_next = CAPTURE;
      CAPTURE: state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg <= IDLE;
      word_reg  <= '0;
      dat_reg   <= '0;
      sel_reg   <= '0;
      we_reg    <= 1'b0;
      ack_reg   <= 1'b0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == IDLE) && req) begin
        word_reg <= wbs_adr_i[N+1:2];
        dat_reg  <= wbs_dat_i;
        sel_reg  <= wbs_sel_i;
        we_reg   <= wbs_we_i;
      end
      // The ack goes out only if the master is still holding the cycle open.
      ack_reg <= (state_reg == CAPTURE) ? wbs_cyc_i : 1'b0;
      if (state_reg == CAPTURE) begin
        rdata_reg <= we_reg ? '0 : bram_do;
      end
    end
  end

  assign bram_en   = (state_reg == ACCESS);
  assign bram_we   = ((state_reg == ACCESS) && we_reg) ? sel_reg : 4'b0000;
  assign bram_a    = {{(32-N){1'b0}}, word_reg};
  assign bram_di   = dat_reg;
  assign wbs_ack_o = ack_reg;
  assign wbs_dat_o = rdata_reg;

endmodule

// File: tb/tb_wb_bram_ctrl.sv
// Bench for wb_bram_ctrl: instance 0 is built with DELAYS=10 and instance 1 with DELAYS=0.
// Each instance has its own BRAM model; a high-level memory model supplies every expected value.
`timescale 1ns/1ps
module tb_wb_bram_ctrl;

  localparam int          NI   = 2;
  localparam logic [31:0] BASE = 32'h3800_0000;
  localparam logic [31:0] MASK = 32'hFFC0_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cyc [NI];
  logic        stb [NI];
  logic        we  [NI];
  logic [3:0]  sel [NI];
  logic [31:0] adr [NI];
  logic [31:0] wdat[NI];
  logic        ack [NI];
  logic [31:0] rdat[NI];
  logic [3:0]  bwe [NI];
  logic        ben [NI];
  logic [31:0] bdi [NI];
  logic [31:0] ba  [NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    logic [31:0] mem [256] = '{default: 32'h0};
    logic [31:0] do_r = 32'h0;

    wb_bram_ctrl #(.DELAYS((gi == 0) ? 10 : 0)) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .wbs_cyc_i (cyc[gi]),
      .wbs_stb_i (stb[gi]),
      .wbs_we_i  (we[gi]),
      .wbs_sel_i (sel[gi]),
      .wbs_adr_i (adr[gi]),
      .wbs_dat_i (wdat[gi]),
      .wbs_ack_o (ack[gi]),
      .wbs_dat_o (rdat[gi]),
      .bram_we   (bwe[gi]),
      .bram_en   (ben[gi]),
      .bram_di   (bdi[gi]),
      .bram_a    (ba[gi]),
      .bram_do   (do_r)
    );

    // BRAM model: read-before-write, one cycle of latency, and outputs 0 when not enabled.
    always @(posedge clk) begin
      if (ben[gi]) begin
        do_r <= mem[ba[gi][7:0]];
        for (int b = 0; b < 4; b++)
          if (bwe[gi][b]) mem[ba[gi][7:0]][8*b +: 8] <= bdi[gi][8*b +: 8];
      end else begin
        do_r <= 32'h0;
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] ref_mem [NI][256];

  typedef struct {
    int          en_cnt;
    int          en_cyc;
    int          ack_cnt;
    int          ack_cyc;
    logic [31:0] a;
    logic [31:0] di;
    logic [3:0]  bw;
    logic [31:0] rd;
  } xres_t;

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    bit          exp_hit;
    logic [31:0] exp_a;
    logic [31:0] exp_rd;
  } vec_t;

  function automatic int dly(input int inst);
    return (inst == 0) ? 10 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drives one request and records everything the DUT does over a fixed window of cycles.
  task automatic run_xfer(input int inst, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int win, input int abort_at, input int rst_at,
                          output xres_t r);
    bit saw_ack;
    r = '{en_cnt: 0, en_cyc: -1, ack_cnt: 0, ack_cyc: -1, a: 0, di: 0, bw: 0, rd: 0};
    @(posedge clk); #1;
    cyc[inst] = 1'b1; stb[inst] = 1'b1; we[inst] = w;
    adr[inst] = a; wdat[inst] = d; sel[inst] = s;
    for (int c = 0; c < win; c++) begin
      if (c == abort_at || c == rst_at) begin cyc[inst] = 1'b0; stb[inst] = 1'b0; end
      if (c == rst_at) rst = 1'b1;
      @(negedge clk);
      saw_ack = ack[inst];
      if (ben[inst]) begin
        r.en_cnt++; r.en_cyc = c; r.a = ba[inst]; r.di = bdi[inst]; r.bw = bwe[inst];
      end
      if (saw_ack) begin r.ack_cnt++; r.ack_cyc = c; r.rd = rdat[inst]; end
      @(posedge clk); #1;
      rst = 1'b0;
      if (saw_ack) begin cyc[inst] = 1'b0; stb[inst] = 1'b0; end
    end
  endtask

  // Runs a normal transaction, then checks it against the memory model.
  task automatic xact(input int inst, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output xres_t r);
    bit          hit;
    int          word;
    logic [31:0] exp_rd;
    string       t;
    hit  = ((a & MASK) == BASE);
    word = int'((a >> 2) % 256);
    run_xfer(inst, w, a, d, s, hit ? dly(inst) + 8 : 30, -1, -1, r);
    $display("xfer inst=%0d we=%0d adr=%h dat=%h sel=%h en=%0d@%0d ack=%0d@%0d rd=%h",
             inst, w, a, d, s, r.en_cnt, r.en_cyc, r.ack_cnt, r.ack_cyc, r.rd);
    t = $sformatf("i%0d_%h", inst, a);
    if (hit) begin
      exp_rd = w ? 32'h0 : ref_mem[inst][word];
      if (w)
        for (int b = 0; b < 4; b++)
          if (s[b]) ref_mem[inst][word][8*b +: 8] = d[8*b +: 8];
      chk({t, ".en_cnt"},  r.en_cnt,  1);
      chk({t, ".en_cyc"},  r.en_cyc,  dly(inst) + 1);
      chk({t, ".bram_a"},  r.a,       word);
      chk({t, ".bram_di"}, r.di,      d);
      chk({t, ".bram_we"}, r.bw,      w ? s : 4'h0);
      chk({t, ".ack_cnt"}, r.ack_cnt, 1);
      chk({t, ".ack_cyc"}, r.ack_cyc, dly(inst) + 3);
      chk({t, ".dat_o"},   r.rd,      exp_rd);
    end else begin
      chk({t, ".miss_en"},  r.en_cnt,  0);
      chk({t, ".miss_ack"}, r.ack_cnt, 0);
    end
  endtask

  vec_t  vecs [9];
  xres_t r;

  initial begin
    for (int i = 0; i < NI; i++) begin
      cyc[i] = 0; stb[i] = 0; we[i] = 0; sel[i] = 0; adr[i] = 0; wdat[i] = 0;
      for (int k = 0; k < 256; k++) ref_mem[i][k] = 32'h0;
    end

    vecs[0] = '{1, 32'h3800_0004, 32'hDEAD_BEEF, 4'hF, 1, 32'h01, 32'h0};
    vecs[1] = '{1, 32'h3800_0004, 32'h0000_AB00, 4'h2, 1, 32'h01, 32'h0};
    vecs[2] = '{0, 32'h3800_0004, 32'h0,         4'hF, 1, 32'h01, 32'hDEAD_ABEF};
    vecs[3] = '{0, 32'h3000_0000, 32'h0,         4'hF, 0, 32'h00, 32'h0};
    vecs[4] = '{1, 32'h3800_0008, 32'h1234_5678, 4'h9, 1, 32'h02, 32'h0};
    vecs[5] = '{0, 32'h3800_0008, 32'h0,         4'hF, 1, 32'h02, 32'h1200_0078};
    vecs[6] = '{1, 32'h383F_FFFC, 32'hCAFE_F00D, 4'hF, 1, 32'hFF, 32'h0};
    vecs[7] = '{0, 32'h3800_03FC, 32'h0,         4'hF, 1, 32'hFF, 32'hCAFE_F00D};
    vecs[8] = '{0, 32'h3840_0000, 32'h0,         4'hF, 0, 32'h00, 32'h0};

    // Reset behaviour.
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_ack%0d", i),  ack[i],  0);
      chk($sformatf("rst_dato%0d", i), rdat[i], 0);
      chk($sformatf("rst_en%0d", i),   ben[i],  0);
      chk($sformatf("rst_we%0d", i),   bwe[i],  0);
      chk($sformatf("rst_a%0d", i),    ba[i],   0);
      chk($sformatf("rst_di%0d", i),   bdi[i],  0);
    end
    rst = 1'b0;
    begin
      int en_seen = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (ben[0] || ben[1] || ack[0] || ack[1]) en_seen++;
      end
      chk("idle_activity", en_seen, 0);
    end

    // Table-driven vectors on the DELAYS=10 instance.
    for (int v = 0; v < 9; v++) begin
      xact(0, vecs[v].w, vecs[v].a, vecs[v].d, vecs[v].s, r);
      chk($sformatf("tbl%0d.ack", v), r.ack_cnt, vecs[v].exp_hit ? 1 : 0);
      if (vecs[v].exp_hit) begin
        chk($sformatf("tbl%0d.a", v),  r.a,  vecs[v].exp_a);
        chk($sformatf("tbl%0d.rd", v), r.rd, vecs[v].exp_rd);
      end
    end

    // Dropping cyc partway through WAIT must abort the write.
    run_xfer(0, 1, 32'h3800_0004, 32'h5555_5555, 4'hF, 18, 5, -1, r);
    $display("xfer abort en=%0d ack=%0d", r.en_cnt, r.ack_cnt);
    chk("abort.en", r.en_cnt, 0);
    chk("abort.ack", r.ack_cnt, 0);
    // Reset asserted during WAIT.
    run_xfer(0, 1, 32'h3800_0004, 32'h6666_6666, 4'hF, 18, -1, 3, r);
    $display("xfer reset_in_wait en=%0d ack=%0d", r.en_cnt, r.ack_cnt);
    chk("rstwait.en", r.en_cnt, 0);
    chk("rstwait.ack", r.ack_cnt, 0);
    xact(0, 0, 32'h3800_0004, 32'h0, 4'hF, r);
    chk("after_abort.rd", r.rd, 32'hDEAD_ABEF);

    // DELAYS=0: an address aliased onto word 0, then back-to-back reads with cyc held high.
    xact(1, 1, 32'h3800_0400, 32'h1122_3344, 4'hF, r);
    chk("alias.a", r.a, 32'h0);
    begin
      int nack = 0;
      bit saw;
      @(posedge clk); #1;
      cyc[1] = 1; stb[1] = 1; we[1] = 0; sel[1] = 4'hF; adr[1] = 32'h3800_0000;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        saw = ack[1];
        if (saw) begin
          chk($sformatf("b2b%0d.cyc", nack), c, (nack == 0) ? 3 : 7);
          chk($sformatf("b2b%0d.rd", nack), rdat[1], 32'h1122_3344);
          nack++;
        end
        @(posedge clk); #1;
        if (saw) begin
          if (nack == 1) adr[1] = 32'h3800_0800;
          else begin cyc[1] = 0; stb[1] = 0; end
        end
      end
      $display("xfer b2b acks=%0d", nack);
      chk("b2b.count", nack, 2);
    end

    // Randomised traffic on both instances.
    for (int k = 0; k < 40; k++) begin
      int          inst;
      logic [31:0] a;
      inst = k % 2;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = (a & ~MASK) | BASE;
      else if ((a & MASK) == BASE) a = a ^ 32'h8000_0000;
      a = (a & ~32'h0000_03FC) | (32'($urandom_range(0, 7)) << 2);
      xact(inst, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
